// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI main-bus master and its request FIFO.
// Provides main-bus command encodings, default bus widths, the master FSM
// state type and a legality check for CPU-requested commands.
package mesi_isc_pkg;

    localparam int unsigned MbusCmdWidth  = 3;
    localparam int unsigned MbusAddrWidth = 32;

    localparam logic [MbusCmdWidth-1:0] MbusCmdNop     = 3'd0;
    localparam logic [MbusCmdWidth-1:0] MbusCmdWr      = 3'd1;
    localparam logic [MbusCmdWidth-1:0] MbusCmdRd      = 3'd2;
    localparam logic [MbusCmdWidth-1:0] MbusCmdWrBroad = 3'd3;
    localparam logic [MbusCmdWidth-1:0] MbusCmdRdBroad = 3'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StGap   = 2'd2
    } mbus_state_e;

    // NOP and the unused codes 5-7 are never queued.
    function automatic logic is_legal_cmd(input logic [MbusCmdWidth-1:0] cmd);
        return (cmd == MbusCmdWr) || (cmd == MbusCmdRd) ||
               (cmd == MbusCmdWrBroad) || (cmd == MbusCmdRdBroad);
    endfunction

endpackage

// File: rtl/mesi_mbus_req_fifo.sv
// Request queue for the main-bus master.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   push_i     - write data_i (ignored when full, even if popping)
//   data_i     - {cmd, addr} entry to enqueue
//   pop_i      - drop the head entry (ignored when empty)
//   data_o     - head entry
//   full_o     - DEPTH entries held
//   count_o    - occupancy, 0..DEPTH
module mesi_mbus_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mesi_mbus_master.sv
// Main-bus master: queues CPU requests and issues them one at a time to the
// coherence controller, holding each command until acknowledged.
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   req_valid_i/req_ready_o  - CPU request handshake (ready = queue not full)
//   req_cmd_i, req_addr_i    - requested main-bus command and address
//   mbus_cmd_o, mbus_addr_o  - registered command/address to the controller
//   mbus_ack_i               - acknowledge from the controller
//   cpu_busy_o               - queue non-empty or transaction in flight
//   done_o                   - pulse per completed transaction
//   err_illegal_o            - pulse, illegal request dropped
//   err_spurious_o           - pulse, ack with nothing outstanding
//   timeout_o                - sticky, an ack wait reached TIMEOUT_CYCLES
module mesi_mbus_master
    import mesi_isc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = mesi_isc_pkg::MbusAddrWidth,
    parameter int unsigned CMD_WIDTH      = mesi_isc_pkg::MbusCmdWidth,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [CMD_WIDTH-1:0]  req_cmd_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic [CMD_WIDTH-1:0]  mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0] mbus_addr_o,
    input  logic                  mbus_ack_i,
    output logic                  cpu_busy_o,
    output logic                  done_o,
    output logic                  err_illegal_o,
    output logic                  err_spurious_o,
    output logic                  timeout_o
);

    localparam int unsigned EntryW = CMD_WIDTH + ADDR_WIDTH;
    localparam int unsigned WaitW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT_CYCLES);

    mbus_state_e state_q, state_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic done_q, done_d;
    logic illegal_q, illegal_d;
    logic spurious_q, spurious_d;
    logic timeout_q, timeout_d;

    logic                     cmd_legal;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryW-1:0]        fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [CMD_WIDTH-1:0]     head_cmd;
    logic [ADDR_WIDTH-1:0]    head_addr;

    assign cmd_legal   = is_legal_cmd(req_cmd_i);
    assign req_ready_o = !fifo_full;
    assign fifo_push   = req_valid_i && req_ready_o && cmd_legal;
    assign fifo_empty  = (fifo_count == '0);
    assign {head_cmd, head_addr} = fifo_head;

    mesi_mbus_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  ({req_cmd_i, req_addr_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        spurious_d = 1'b0;
        fifo_pop   = 1'b0;
        illegal_d  = req_valid_i && req_ready_o && !cmd_legal;

        unique case (state_q)
            StIdle, StGap: begin
                spurious_d = mbus_ack_i;
                if (!fifo_empty) begin
                    state_d = StIssue;
                    cmd_d   = head_cmd;
                    addr_d  = head_addr;
                    wait_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (wait_q != WaitMax) begin
                    wait_d = wait_q + 1'b1;
                end
                if (wait_d == WaitMax) begin
                    timeout_d = 1'b1;
                end
                if (mbus_ack_i) begin
                    fifo_pop = 1'b1;
                    done_d   = 1'b1;
                    cmd_d    = CMD_WIDTH'(MbusCmdNop);
                    addr_d   = '0;
                    state_d  = StGap;
                end
            end
            default: begin
                state_d = StIdle;
                cmd_d   = CMD_WIDTH'(MbusCmdNop);
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cmd_q      <= CMD_WIDTH'(MbusCmdNop);
            addr_q     <= '0;
            wait_q     <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            spurious_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            spurious_q <= spurious_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mbus_cmd_o     = cmd_q;
    assign mbus_addr_o    = addr_q;
    assign done_o         = done_q;
    assign err_illegal_o  = illegal_q;
    assign err_spurious_o = spurious_q;
    assign timeout_o      = timeout_q;
    assign cpu_busy_o     = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_mesi_mbus_master.sv
// Bench for mesi_mbus_master: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level queue model.
module tb_mesi_mbus_master;

    localparam int unsigned Depth   = 4;
    localparam int unsigned Timeout = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_cmd_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [2:0]  mbus_cmd_o;
    logic [31:0] mbus_addr_o;
    logic        mbus_ack_i = 1'b0;
    logic        cpu_busy_o, done_o, err_illegal_o, err_spurious_o, timeout_o;

    mesi_mbus_master #(
        .ADDR_WIDTH     (32),
        .CMD_WIDTH      (3),
        .FIFO_DEPTH     (Depth),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_cmd_i      (req_cmd_i),
        .req_addr_i     (req_addr_i),
        .mbus_cmd_o     (mbus_cmd_o),
        .mbus_addr_o    (mbus_addr_o),
        .mbus_ack_i     (mbus_ack_i),
        .cpu_busy_o     (cpu_busy_o),
        .done_o         (done_o),
        .err_illegal_o  (err_illegal_o),
        .err_spurious_o (err_spurious_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of pending requests plus whether the head is
    // currently presented on the bus.
    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] addr;
    } req_t;

    req_t q[$];
    bit   on_bus, after_pop, m_done, m_ill, m_spur, m_to;
    int   issue_cycles;

    function automatic bit legal(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd4);
    endfunction

    task automatic model_reset();
        q.delete();
        on_bus = 0; after_pop = 0; m_done = 0; m_ill = 0; m_spur = 0; m_to = 0;
        issue_cycles = 0;
    endtask

    // One clock edge of the model, using the inputs seen at that edge.
    task automatic model_step(input bit v, input logic [2:0] c, input logic [31:0] a,
                              input bit ack);
        bit ready;
        req_t e;
        ready  = (q.size() < Depth);
        m_done = 0;
        m_spur = 0;
        m_ill  = v && ready && !legal(c);
        if (on_bus) begin
            issue_cycles++;
            if (issue_cycles >= Timeout) m_to = 1;
            if (ack) begin
                void'(q.pop_front());
                m_done    = 1;
                on_bus    = 0;
                after_pop = 1;
            end
        end else begin
            // Bus idle for a cycle: any queued request goes out next.
            m_spur    = ack;
            after_pop = 0;
            if (q.size() > 0) begin
                on_bus       = 1;
                issue_cycles = 0;
            end
        end
        if (v && ready && legal(c)) begin
            e.cmd  = c;
            e.addr = a;
            q.push_back(e);
        end
    endtask

    task automatic compare_all();
        check_eq("mbus_cmd", 64'(mbus_cmd_o), on_bus ? 64'(q[0].cmd) : 64'd0);
        check_eq("mbus_addr", 64'(mbus_addr_o), on_bus ? 64'(q[0].addr) : 64'd0);
        check_eq("req_ready", 64'(req_ready_o), 64'(q.size() < Depth));
        check_eq("cpu_busy", 64'(cpu_busy_o), 64'((q.size() > 0) || on_bus || after_pop));
        check_eq("done", 64'(done_o), 64'(m_done));
        check_eq("err_illegal", 64'(err_illegal_o), 64'(m_ill));
        check_eq("err_spurious", 64'(err_spurious_o), 64'(m_spur));
        check_eq("timeout", 64'(timeout_o), 64'(m_to));
    endtask

    // Called just after a negedge; drives inputs for one full cycle.
    task automatic drive_cycle(input bit v, input logic [2:0] c, input logic [31:0] a,
                               input bit ack);
        req_valid_i = v;
        req_cmd_i   = c;
        req_addr_i  = a;
        mbus_ack_i  = ack;
        @(posedge clk);
        model_step(v, c, a, ack);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input bit ack);
        for (int i = 0; i < n; i++) drive_cycle(0, 3'd0, 32'd0, ack);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_cmd", 64'(mbus_cmd_o), 64'd0);
        check_eq("rst_addr", 64'(mbus_addr_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_busy", 64'(cpu_busy_o), 64'd0);
        check_eq("rst_timeout", 64'(timeout_o), 64'd0);
        req_valid_i = 1'b0;
        mbus_ack_i  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_ready", 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Single read, acked on the 4th cycle it is on the bus.
        drive_cycle(1, 3'd2, 32'h100, 0);
        idle_cycles(1, 0);
        check_eq("rd_on_bus", 64'(mbus_cmd_o), 64'd2);
        idle_cycles(3, 0);
        drive_cycle(0, 3'd0, 32'd0, 1);
        check_eq("rd_done", 64'(done_o), 64'd1);
        idle_cycles(3, 0);

        // Five writes with no ack: four accepted, first held on the bus.
        for (int i = 0; i < 5; i++) drive_cycle(1, 3'd1, 32'h200 + 32'(i * 4), 0);
        check_eq("full_ready", 64'(req_ready_o), 64'd0);
        check_eq("full_head", 64'(mbus_addr_o), 64'h200);

        // Keep stalling past the timeout, then drain with late acks.
        idle_cycles(6, 0);
        check_eq("timeout_set", 64'(timeout_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 3'd0, 32'd0, 1);
            idle_cycles(2, 0);
        end
        idle_cycles(2, 0);

        // Illegal request, then spurious ack while idle.
        drive_cycle(1, 3'd6, 32'h300, 0);
        idle_cycles(1, 0);
        check_eq("illegal_pulse_gone", 64'(err_illegal_o), 64'd0);
        drive_cycle(0, 3'd0, 32'd0, 1);
        idle_cycles(2, 0);

        // Reset mid-issue with three queued.
        for (int i = 0; i < 3; i++) drive_cycle(1, 3'd4, 32'h400 + 32'(i), 0);
        idle_cycles(1, 0);
        do_reset();
        idle_cycles(3, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                        ($urandom_range(0, 2) == 0));
            if (i == 1500) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
